// File: rtl/axi_rd_bridge_mo.sv
// Read-path bridge: arbitrates the inst and data SRAM-like ports onto one AXI3 AR
// channel, tracks outstanding reads per port and routes R beats back by RID.
module axi_rd_bridge_mo #(
  parameter int unsigned MAX_OUT = 4,
  parameter logic [3:0]  INST_ID = 4'd0,
  parameter logic [3:0]  DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [7:0]  rd_outstanding
);

  localparam int unsigned CW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          arvalid_q, arvalid_d;
  logic [3:0]    arid_q, arid_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [2:0]    arsize_q, arsize_d;
  logic [CW-1:0] inst_cnt_q, inst_cnt_d;
  logic [CW-1:0] data_cnt_q, data_cnt_d;
  logic          inst_ok_q, data_ok_q;
  logic [DW-1:0] inst_rdata_q, inst_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;
  logic          rready_q;

  logic slot_free_c, data_elig_c, inst_elig_c, grant_d_c, grant_i_c;
  logic inst_hit_c, data_hit_c;
  logic unused_c;

  // Arbitration: data wins over inst; AR slot may refill on the handshake cycle.
  always_comb begin
    slot_free_c = ~arvalid_q | arready;
    data_elig_c = data_sram_req & ~data_sram_wr & (data_cnt_q < CW'(MAX_OUT));
    inst_elig_c = inst_sram_req & (inst_cnt_q < CW'(MAX_OUT));
    grant_d_c   = slot_free_c & data_elig_c;
    grant_i_c   = slot_free_c & inst_elig_c & ~data_elig_c;
  end

  // Beats for unknown IDs or idle ports are consumed and dropped.
  always_comb begin
    data_hit_c = rvalid & rready_q & (rid == DATA_ID) & (data_cnt_q != '0);
    inst_hit_c = rvalid & rready_q & (rid == INST_ID) & (rid != DATA_ID) & (inst_cnt_q != '0);
  end

  always_comb begin
    arvalid_d    = arvalid_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arsize_d     = arsize_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (grant_d_c) begin
      arvalid_d = 1'b1;
      arid_d    = DATA_ID;
      araddr_d  = data_sram_addr;
      arsize_d  = {1'b0, data_sram_size};
    end else if (grant_i_c) begin
      arvalid_d = 1'b1;
      arid_d    = INST_ID;
      araddr_d  = inst_sram_addr;
      arsize_d  = {1'b0, inst_sram_size};
    end else if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
    end
    inst_cnt_d = inst_cnt_q + CW'(grant_i_c) - CW'(inst_hit_c);
    data_cnt_d = data_cnt_q + CW'(grant_d_c) - CW'(data_hit_c);
    if (inst_hit_c) inst_rdata_d = rdata;
    if (data_hit_c) data_rdata_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      arvalid_q    <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arsize_q     <= '0;
      inst_cnt_q   <= '0;
      data_cnt_q   <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      rready_q     <= 1'b0;
    end else begin
      arvalid_q    <= arvalid_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arsize_q     <= arsize_d;
      inst_cnt_q   <= inst_cnt_d;
      data_cnt_q   <= data_cnt_d;
      inst_ok_q    <= inst_hit_c;
      data_ok_q    <= data_hit_c;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      rready_q     <= 1'b1;
    end
  end

  assign inst_sram_addr_ok = grant_i_c;
  assign data_sram_addr_ok = grant_d_c;
  assign inst_sram_data_ok = inst_ok_q;
  assign data_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_rdata   = data_rdata_q;
  assign arvalid           = arvalid_q;
  assign arid              = arid_q;
  assign araddr            = araddr_q;
  assign arsize            = arsize_q;
  assign arlen             = 8'd0;
  assign arburst           = 2'b01;
  assign arlock            = 2'b00;
  assign arcache           = 4'd0;
  assign arprot            = 3'd0;
  assign rready            = rready_q;
  assign rd_outstanding    = {data_cnt_q, inst_cnt_q};

  // Inst port is read-only; response status and burst end carry no information here.
  assign unused_c = ^{inst_sram_wr, rresp, rlast};

endmodule
